ptos_lane_ctrl: RTL and testbench
=================================

PTOS_LANE_CTRL -- requirements
Module: ptos_lane_ctrl

Interface
REQ-001 The block SHALL have port clk32f, input, 1 bit: serial bit clock; all sequential logic on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port active, input, 1 bit: lane enable from the link layer.
REQ-004 The block SHALL have port data_in, input, 8 bits: payload byte offered by the upstream source.
REQ-005 The block SHALL have port data_valid, input, 1 bit: data_in holds a valid byte.
REQ-006 The block SHALL have port data_ready, output, 1 bit: the block accepts data_in this cycle.
REQ-007 The block SHALL have port out, output, 1 bit: serial lane output, MSB first.
REQ-008 The block SHALL have port sym_data, output, 1 bit: the symbol currently on out is payload (1) or IDLE (0).
REQ-009 The block SHALL have port link_up, output, 1 bit: the block is in state RUN.

Function
REQ-010 The block SHALL hold an 8-bit shift register sr, a 3-bit bit counter bit_cnt and a state register {OFF, PRE, RUN}; out SHALL equal sr[7].
REQ-011 The IDLE symbol SHALL be 8'hBC.
REQ-012 OFF: sr = 0, bit_cnt = 0, out = 0; when active = 1 at an edge, the block SHALL load 8'hBC into sr, set bit_cnt = 0 and go to PRE (macro defined) or RUN (macro undefined).
REQ-013 Outside OFF, bit_cnt SHALL increment by 1 per cycle, wrapping 7 -> 0, and sr SHALL shift left by 1 each cycle except at the byte-boundary load.
REQ-014 Byte boundary: the cycle with bit_cnt = 7; at its closing edge the next symbol SHALL be loaded into sr, so there is no gap between symbols.
REQ-015 data_ready SHALL be 1 only when state = RUN, active = 1 and bit_cnt = 7 (combinational decode of registered state).
REQ-016 Transfer occurs when data_ready = 1 and data_valid = 1; data_in SHALL be loaded and sym_data set to 1 for that symbol's 8 cycles.
REQ-017 At a RUN boundary with data_valid = 0, the block SHALL load 8'hBC and set sym_data = 0.
REQ-018 Latency: data_in[7] SHALL appear on out in the cycle after the transfer edge; data_in[0] appears 7 cycles later.
REQ-019 If active falls mid-symbol, the current symbol SHALL complete; at the boundary no data is accepted and the block SHALL enter OFF (out = 0 from the next cycle).
REQ-020 If active = 1 and data_valid = 1 at a PRE boundary, data SHALL NOT be accepted (data_ready = 0).
REQ-021 link_up SHALL be 1 exactly while state = RUN.

Reset
REQ-022 While reset = 0, the block SHALL immediately force state = OFF, sr = 0, bit_cnt = 0, sym_data = 0, and therefore out = 0, data_ready = 0, link_up = 0, regardless of the clock.
REQ-023 Reset asserted mid-symbol SHALL abort the symbol; no partial byte is resumed after release.
REQ-024 After reset release, the block SHALL leave OFF only on a clock edge with active = 1.

Configuration
REQ-025 Macro PTOS_TRAINING_EN defined: PRE SHALL transmit exactly 4 consecutive 8'hBC symbols (32 cycles, 2-bit symbol counter), then enter RUN at the 4th boundary, where the first data_ready occurs; if active falls during PRE, the block SHALL go to OFF at the next boundary.
REQ-026 Macro PTOS_TRAINING_EN undefined: PRE and its counter SHALL not exist; OFF goes directly to RUN, and the first data_ready occurs 7 cycles after leaving OFF.

Verification
REQ-027 Reset held low for 5 cycles with active = 1 and data_valid = 1 -> out = 0, data_ready = 0, link_up = 0 throughout.
REQ-028 Macro undefined; active rises, data_valid = 0 -> out repeats 1,0,1,1,1,1,0,0 with no gaps, sym_data = 0, link_up = 1.
REQ-029 Macro undefined; data_in = 8'hA5 and 8'h3C back-to-back with data_valid = 1 -> two transfers 8 cycles apart; out = 10100101 then 00111100; sym_data = 1 for 16 cycles.
REQ-030 Macro defined; active rises with data_valid = 1, data_in = 8'hFF -> 32 cycles of 8'hBC, first data_ready at cycle 31, then 8 ones on out.
REQ-031 active falls at bit_cnt = 3 during payload 8'h81 -> remaining bits 0,0,0,1 sent, then out = 0, link_up = 0, no further data_ready.
REQ-032 reset pulsed low at bit_cnt = 4 during payload -> out = 0 immediately; after release and active = 1, transmission restarts with a fresh 8'hBC (macro undefined) or the 4-symbol preamble (macro defined).

Source files
------------

// File: rtl/ptos_lane_ctrl.sv
// Serial lane controller: 8-bit symbols shifted out MSB first, IDLE (8'hBC) filling unused slots.
// Define PTOS_TRAINING_EN to add a 4-symbol IDLE preamble (state PRE) before RUN.
module ptos_lane_ctrl (
  input  logic       clk32f,
  input  logic       reset,
  input  logic       active,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       out,
  output logic       sym_data,
  output logic       link_up
);

  localparam logic [7:0] IdleSym = 8'hBC;

`ifdef PTOS_TRAINING_EN
  typedef enum logic [1:0] {
    StOff = 2'b00,
    StPre = 2'b01,
    StRun = 2'b10
  } state_e;
`else
  typedef enum logic [1:0] {
    StOff = 2'b00,
    StRun = 2'b10
  } state_e;
`endif

  state_e     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       sym_data_q, sym_data_d;
  logic       boundary;
  logic       xfer;

`ifdef PTOS_TRAINING_EN
  logic [1:0] sym_cnt_q, sym_cnt_d;
`endif

  assign boundary = (bit_cnt_q == 3'd7);

  // State register
  always_ff @(posedge clk32f or negedge reset) begin
    if (!reset) begin
      state_q <= StOff;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StOff: begin
        if (active) begin
`ifdef PTOS_TRAINING_EN
          state_d = StPre;
`else
          state_d = StRun;
`endif
        end
      end
`ifdef PTOS_TRAINING_EN
      StPre: begin
        if (boundary && !active) begin
          state_d = StOff;
        end else if (sym_cnt_q == 2'd3 && bit_cnt_q == 3'd6) begin
          // RUN covers the boundary cycle of the 4th preamble symbol, so the
          // first transfer lands right after the preamble.
          state_d = StRun;
        end
      end
`endif
      StRun: begin
        if (boundary && !active) begin
          state_d = StOff;
        end
      end
      default: state_d = StOff;
    endcase
  end

  // Output decode
  always_comb begin
    data_ready = (state_q == StRun) && active && boundary;
    xfer       = data_ready && data_valid;
    link_up    = (state_q == StRun);
    out        = sr_q[7];
    sym_data   = sym_data_q;
  end

  // Datapath next-state
  always_comb begin
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    sym_data_d = sym_data_q;
`ifdef PTOS_TRAINING_EN
    sym_cnt_d  = sym_cnt_q;
`endif
    if (state_q == StOff) begin
      sr_d       = active ? IdleSym : 8'h00;
      bit_cnt_d  = 3'd0;
      sym_data_d = 1'b0;
`ifdef PTOS_TRAINING_EN
      sym_cnt_d  = 2'd0;
`endif
    end else if (boundary) begin
      bit_cnt_d = 3'd0;
      if (state_d == StOff) begin
        sr_d       = 8'h00;
        sym_data_d = 1'b0;
      end else if (xfer) begin
        sr_d       = data_in;
        sym_data_d = 1'b1;
      end else begin
        sr_d       = IdleSym;
        sym_data_d = 1'b0;
      end
`ifdef PTOS_TRAINING_EN
      if (state_q == StPre) begin
        sym_cnt_d = sym_cnt_q + 2'd1;
      end
`endif
    end else begin
      sr_d      = {sr_q[6:0], 1'b0};
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk32f or negedge reset) begin
    if (!reset) begin
      sr_q       <= 8'h00;
      bit_cnt_q  <= 3'd0;
      sym_data_q <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      sym_data_q <= sym_data_d;
    end
  end

`ifdef PTOS_TRAINING_EN
  always_ff @(posedge clk32f or negedge reset) begin
    if (!reset) begin
      sym_cnt_q <= 2'd0;
    end else begin
      sym_cnt_q <= sym_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_ptos_lane_ctrl.sv
// Bench for ptos_lane_ctrl: directed scenarios then random traffic, checked each cycle
// against a symbol-level model (byte + bit position, not a shift register).
module tb_ptos_lane_ctrl;

  logic       clk32f = 1'b0;
  logic       reset = 1'b0;
  logic       active = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic       out;
  logic       sym_data;
  logic       link_up;

  ptos_lane_ctrl dut (
    .clk32f    (clk32f),
    .reset     (reset),
    .active    (active),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .out       (out),
    .sym_data  (sym_data),
    .link_up   (link_up)
  );

  initial forever #5 clk32f = ~clk32f;

`ifdef PTOS_TRAINING_EN
  localparam int PreSyms = 4;
`else
  localparam int PreSyms = 0;
`endif

  int checks = 0;
  int errors = 0;

  // Model: lane on/off, current symbol byte and which of its 8 bits is on the wire.
  bit         m_on;
  int         m_pre_left;
  int         m_pos;
  logic [7:0] m_byte;
  bit         m_is_data;
  bit         m_took;

  function automatic void model_clear();
    m_on = 0; m_pre_left = 0; m_pos = 0; m_byte = 8'h00; m_is_data = 0;
  endfunction

  function automatic bit model_link();
    return m_on && (m_pre_left == 0 || (m_pre_left == 1 && m_pos == 7));
  endfunction

  function automatic void model_edge();
    if (!reset) begin
      model_clear();
    end else if (!m_on) begin
      if (active) begin
        m_on = 1; m_pos = 0; m_byte = 8'hBC; m_is_data = 0; m_pre_left = PreSyms;
      end
    end else if (m_pos < 7) begin
      m_pos++;
    end else if (!active) begin
      model_clear();
    end else begin
      m_pos = 0;
      if (m_pre_left > 1) begin
        m_pre_left--;
        m_byte = 8'hBC; m_is_data = 0;
      end else begin
        m_pre_left = 0;
        if (data_valid) begin
          m_byte = data_in; m_is_data = 1; m_took = 1;
        end else begin
          m_byte = 8'hBC; m_is_data = 0;
        end
      end
    end
  endfunction

  task automatic check_outputs();
    logic e_out, e_link, e_ready, e_sym;
    e_out   = m_on ? m_byte[7-m_pos] : 1'b0;
    e_link  = model_link();
    e_ready = e_link && active && (m_pos == 7);
    e_sym   = m_on && m_is_data;
    checks += 4;
    assert (out === e_out) else begin
      errors++; $error("FAIL out: observed %0b expected %0b at %0t", out, e_out, $time);
    end
    assert (link_up === e_link) else begin
      errors++; $error("FAIL link_up: observed %0b expected %0b at %0t", link_up, e_link, $time);
    end
    assert (data_ready === e_ready) else begin
      errors++;
      $error("FAIL data_ready: observed %0b expected %0b at %0t", data_ready, e_ready, $time);
    end
    assert (sym_data === e_sym) else begin
      errors++; $error("FAIL sym_data: observed %0b expected %0b at %0t", sym_data, e_sym, $time);
    end
  endtask

  task automatic step(input logic a, input logic dv, input logic [7:0] d);
    active = a; data_valid = dv; data_in = d;
    @(posedge clk32f);
    model_edge();
    @(negedge clk32f);
    check_outputs();
  endtask

  task automatic send_byte(input logic [7:0] b);
    m_took = 0;
    for (int i = 0; i < 64 && !m_took; i++) step(1'b1, 1'b1, b);
    checks++;
    assert (m_took === 1'b1) else begin
      errors++; $error("FAIL send_timeout: observed %0b expected %0b", m_took, 1'b1);
    end
  endtask

  task automatic pulse_reset(input int cycles);
    reset = 1'b0;
    #1;
    model_clear();
    check_outputs();
    for (int i = 0; i < cycles; i++) step(1'b1, 1'b1, 8'hAA);
    reset = 1'b1;
  endtask

  initial begin
    model_clear();
    m_took = 0;
    @(negedge clk32f);
    check_outputs();
    // Reset held with active and valid asserted
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'hAA);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h55);
    // Idle pattern (and preamble when enabled)
    for (int i = 0; i < 44; i++) step(1'b1, 1'b0, 8'h00);
    // Back-to-back payload
    send_byte(8'hA5);
    send_byte(8'h3C);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'h00);
    // active falls at bit 3 of 8'h81
    send_byte(8'h81);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 8'h77);
    // Reset at bit 4 of a payload symbol, then restart
    send_byte(8'h5A);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00);
    pulse_reset(2);
    for (int i = 0; i < 44; i++) step(1'b1, 1'b0, 8'h00);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        pulse_reset($urandom_range(0, 3));
      end else begin
        step(($urandom_range(0, 31) != 0), 1'($urandom_range(0, 1)), 8'($urandom));
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
